// File: rtl/stream_out_rr_arbiter.sv
// stream_out_rr_arbiter: shares one stream_out link between freespace-update
// requests (priority, burst-limited) and output-port FIFO data, round-robin
// within each class; holds the last packet while the router asserts resend.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   resend                     router back-pressure, re-drive last packet
//   freespace_update           level request per input port
//   packet_from_input_ports    freespace packet per input port (flattened)
//   empty                      FWFT output FIFO empty flags
//   packet_from_output_ports   FWFT head word per output FIFO (flattened)
//   freespace_ack              one-hot 1-cycle grant to an input port
//   outport_sel                one-hot 1-cycle FIFO pop
//   stream_out                 registered packet to the router
//   grant_cnt                  per-requester grant counters (ARB_GRANT_CNT_EN)
//
// Optional feature macro: ARB_GRANT_CNT_EN
module stream_out_rr_arbiter #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_IN_PORTS  = 7,
  parameter int NUM_OUT_PORTS = 7,
  parameter int MAX_FS_BURST  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 resend,
  input  logic [NUM_IN_PORTS-1:0]              freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]  packet_from_input_ports,
  input  logic [NUM_OUT_PORTS-1:0]             empty,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] packet_from_output_ports,
  output logic [NUM_IN_PORTS-1:0]              freespace_ack,
  output logic [NUM_OUT_PORTS-1:0]             outport_sel,
`ifdef ARB_GRANT_CNT_EN
  output logic [16*(NUM_IN_PORTS+NUM_OUT_PORTS)-1:0] grant_cnt,
`endif
  output logic [PACKET_BITS-1:0]               stream_out
);

  localparam int FSW = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
  localparam int OPW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  typedef enum logic {ARB, HOLD} state_t;

  state_t         state_q, state_d;
  logic [FSW-1:0] fs_ptr, fs_win;
  logic [OPW-1:0] op_ptr, op_win;
  logic [3:0]     fs_burst;
  logic           fs_hit, op_hit;
  logic           data_pending;
  logic           fs_go, op_go;

  // Resend is honoured in the cycle it is seen, so the registered state
  // only tracks whether the link is currently being held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     state_d = resend ? HOLD : ARB;
      HOLD:    state_d = resend ? HOLD : ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin : fs_pick
    int idx;
    idx    = 0;
    fs_hit = 1'b0;
    fs_win = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      idx = (int'(fs_ptr) + i) % NUM_IN_PORTS;
      if (!fs_hit && freespace_update[idx]) begin
        fs_hit = 1'b1;
        fs_win = FSW'(idx);
      end
    end
  end

  always_comb begin : op_pick
    int idx;
    idx    = 0;
    op_hit = 1'b0;
    op_win = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      idx = (int'(op_ptr) + i) % NUM_OUT_PORTS;
      if (!op_hit && !empty[idx]) begin
        op_hit = 1'b1;
        op_win = OPW'(idx);
      end
    end
  end

  assign data_pending = |(~empty);

  // Data gets a slot once the freespace burst limit is reached.
  assign fs_go = !reset && !resend && fs_hit &&
                 ((fs_burst < 4'(MAX_FS_BURST)) || !data_pending);
  assign op_go = !reset && !resend && !fs_go && op_hit;

  assign freespace_ack = fs_go ? (NUM_IN_PORTS'(1) << fs_win) : '0;
  assign outport_sel   = op_go ? (NUM_OUT_PORTS'(1) << op_win) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB;
      fs_ptr     <= '0;
      op_ptr     <= '0;
      fs_burst   <= '0;
      stream_out <= '0;
    end else begin
      state_q <= state_d;
      if (!resend) begin
        if (fs_go) begin
          stream_out <= packet_from_input_ports[int'(fs_win)*PACKET_BITS +: PACKET_BITS];
          fs_ptr     <= (fs_win == FSW'(NUM_IN_PORTS-1)) ? '0 : fs_win + 1'b1;
          if (fs_burst != 4'hF)
            fs_burst <= fs_burst + 4'd1;
        end else if (op_go) begin
          stream_out <= packet_from_output_ports[int'(op_win)*PACKET_BITS +: PACKET_BITS];
          op_ptr     <= (op_win == OPW'(NUM_OUT_PORTS-1)) ? '0 : op_win + 1'b1;
          fs_burst   <= '0;
        end else begin
          stream_out <= '0;
        end
      end
    end
  end

`ifdef ARB_GRANT_CNT_EN
  localparam int NREQ = NUM_IN_PORTS + NUM_OUT_PORTS;

  logic [NREQ-1:0] grant_vec;
  assign grant_vec = {outport_sel, freespace_ack};

  // Grants are already masked during HOLD, which freezes the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_vec[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_out_rr_arbiter.sv
// Directed testbench for stream_out_rr_arbiter.
// Checks priority, round-robin, burst limit, resend hold, wrap and reset.
module tb_stream_out_rr_arbiter;

  localparam int PB = 97;
  localparam int NI = 7;
  localparam int NO = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic            resend;
  logic [NI-1:0]   freespace_update;
  logic [PB*NI-1:0] in_bus;
  logic [NO-1:0]   empty;
  logic [PB*NO-1:0] out_bus;
  logic [NI-1:0]   freespace_ack;
  logic [NO-1:0]   outport_sel;
  logic [PB-1:0]   stream_out;
`ifdef ARB_GRANT_CNT_EN
  logic [16*(NI+NO)-1:0] grant_cnt;
`endif

  int pass_cnt = 0;
  int total    = 0;

  stream_out_rr_arbiter dut (
    .clk                      (clk),
    .reset                    (reset),
    .resend                   (resend),
    .freespace_update         (freespace_update),
    .packet_from_input_ports  (in_bus),
    .empty                    (empty),
    .packet_from_output_ports (out_bus),
    .freespace_ack            (freespace_ack),
    .outport_sel              (outport_sel),
`ifdef ARB_GRANT_CNT_EN
    .grant_cnt                (grant_cnt),
`endif
    .stream_out               (stream_out)
  );

  always #5 clk = ~clk;

  function automatic logic [PB-1:0] fs_pkt(int i);
    return {1'b1, 64'h0, 32'hF5000000 + 32'(i)};
  endfunction

  function automatic logic [PB-1:0] op_word(int p, int s);
    return {1'b1, 32'(s), 32'h0, 32'hD0000000 + 32'(p)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_buses;
    for (int i = 0; i < NI; i++) in_bus[i*PB +: PB] = fs_pkt(i);
    for (int i = 0; i < NO; i++) out_bus[i*PB +: PB] = op_word(i, 0);
  endtask

  task automatic apply_reset;
    reset            = 1'b1;
    resend           = 1'b0;
    freespace_update = '0;
    empty            = '1;
    load_buses();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset            = 1'b1;
    resend           = 1'b0;
    freespace_update = '1;
    empty            = '0;
    load_buses();
    #1;
    total++;
    if (freespace_ack !== '0 || outport_sel !== '0)
      $display("FAIL reset_grants: ack=%h sel=%h want 0 0", freespace_ack, outport_sel);
    else pass_cnt++;
    tick();
    total++;
    if (stream_out !== '0)
      $display("FAIL reset_stream: got %h want 0", stream_out);
    else pass_cnt++;
    freespace_update = '0;
    empty = '1;
    reset = 1'b0;
    #1;
    total++;
    if (freespace_ack !== '0 || outport_sel !== '0)
      $display("FAIL idle_grants: ack=%h sel=%h want 0 0", freespace_ack, outport_sel);
    else pass_cnt++;
    tick();
    total++;
    if (stream_out !== '0)
      $display("FAIL idle_stream: got %h want 0", stream_out);
    else pass_cnt++;
  endtask

  task automatic test_single_fifo;
    apply_reset();
    empty = 7'h7E;
    #1;
    total++;
    if (outport_sel !== 7'h01 || freespace_ack !== '0)
      $display("FAIL single_sel: sel=%h ack=%h want 01 00", outport_sel, freespace_ack);
    else pass_cnt++;
    tick();
    total++;
    if (stream_out !== op_word(0, 0))
      $display("FAIL single_stream: got %h want %h", stream_out, op_word(0, 0));
    else pass_cnt++;
    empty = 7'h7F;
    #1;
    total++;
    if (outport_sel !== '0)
      $display("FAIL empty_no_pop: sel=%h want 00", outport_sel);
    else pass_cnt++;
    tick();
    total++;
    if (stream_out !== '0)
      $display("FAIL idle_after_pop: got %h want 0", stream_out);
    else pass_cnt++;
  endtask

  task automatic test_op_round_robin;
    int ex [9] = '{0, 1, 2, 3, 4, 5, 6, 0, 1};
    apply_reset();
    empty = '0;
    for (int k = 0; k < 9; k++) begin
      #1;
      total++;
      if (outport_sel !== 7'(1 << ex[k]))
        $display("FAIL op_rr_sel[%0d]: got %h want %h", k, outport_sel, 7'(1 << ex[k]));
      else pass_cnt++;
      tick();
      total++;
      if (stream_out !== op_word(ex[k], 0))
        $display("FAIL op_rr_stream[%0d]: got %h want %h", k, stream_out, op_word(ex[k], 0));
      else pass_cnt++;
    end
  endtask

  task automatic test_fs_burst;
    int ex_i [10] = '{0, 2, 0, 2, 3, 0, 2, 0, 2, 3};
    bit ex_f [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [NI-1:0] ea;
    logic [NO-1:0] es;
    logic [PB-1:0] eo;
    apply_reset();
    freespace_update = 7'h05;
    empty = 7'h77;
    for (int k = 0; k < 10; k++) begin
      ea = ex_f[k] ? 7'(1 << ex_i[k]) : 7'h0;
      es = ex_f[k] ? 7'h0 : 7'(1 << ex_i[k]);
      eo = ex_f[k] ? fs_pkt(ex_i[k]) : op_word(ex_i[k], 0);
      #1;
      total++;
      if (freespace_ack !== ea || outport_sel !== es)
        $display("FAIL burst_grant[%0d]: ack=%h sel=%h want %h %h", k, freespace_ack, outport_sel, ea, es);
      else pass_cnt++;
      total++;
      if ((|freespace_ack) && (|outport_sel))
        $display("FAIL exclusive[%0d]: ack=%h sel=%h want one zero", k, freespace_ack, outport_sel);
      else pass_cnt++;
      tick();
      total++;
      if (stream_out !== eo)
        $display("FAIL burst_stream[%0d]: got %h want %h", k, stream_out, eo);
      else pass_cnt++;
    end
    freespace_update = 7'h01;
    empty = 7'h7F;
    for (int k = 0; k < 6; k++) begin
      #1;
      total++;
      if (freespace_ack !== 7'h01)
        $display("FAIL fs_unlimited[%0d]: got %h want 01", k, freespace_ack);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_resend;
    int seq = 0;
    apply_reset();
    empty = 7'h7B;
    out_bus[2*PB +: PB] = op_word(2, 0);
    for (int k = 0; k < 5; k++) begin
      resend = (k >= 2 && k < 5) ? 1'b1 : 1'b0;
      if (k == 4) resend = 1'b1;
      #1;
      if (resend) begin
        total++;
        if (outport_sel !== '0 || freespace_ack !== '0)
          $display("FAIL hold_sel[%0d]: sel=%h ack=%h want 00 00", k, outport_sel, freespace_ack);
        else pass_cnt++;
        tick();
        total++;
        if (stream_out !== op_word(2, seq - 1))
          $display("FAIL hold_stream[%0d]: got %h want %h", k, stream_out, op_word(2, seq - 1));
        else pass_cnt++;
      end else begin
        total++;
        if (outport_sel !== 7'h04)
          $display("FAIL stream_sel[%0d]: got %h want 04", k, outport_sel);
        else pass_cnt++;
        tick();
        total++;
        if (stream_out !== op_word(2, seq))
          $display("FAIL stream_word[%0d]: got %h want %h", k, stream_out, op_word(2, seq));
        else pass_cnt++;
        seq++;
        out_bus[2*PB +: PB] = op_word(2, seq);
      end
    end
    resend = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (outport_sel !== 7'h04)
        $display("FAIL resume_sel[%0d]: got %h want 04", k, outport_sel);
      else pass_cnt++;
      tick();
      total++;
      if (stream_out !== op_word(2, seq))
        $display("FAIL resume_word[%0d]: got %h want %h", k, stream_out, op_word(2, seq));
      else pass_cnt++;
      seq++;
      out_bus[2*PB +: PB] = op_word(2, seq);
    end
  endtask

  task automatic test_fs_wrap;
    logic [NI-1:0] req [3] = '{7'h20, 7'h40, 7'h41};
    int ex [3] = '{5, 6, 0};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      freespace_update = req[k];
      #1;
      total++;
      if (freespace_ack !== 7'(1 << ex[k]))
        $display("FAIL wrap_ack[%0d]: got %h want %h", k, freespace_ack, 7'(1 << ex[k]));
      else pass_cnt++;
      tick();
      total++;
      if (stream_out !== fs_pkt(ex[k]))
        $display("FAIL wrap_stream[%0d]: got %h want %h", k, stream_out, fs_pkt(ex[k]));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    int pre [6] = '{0, 1, 2, 3, 0, 4};
    bit pre_f [6] = '{1, 1, 1, 1, 0, 1};
    int post [5] = '{0, 1, 2, 3, 0};
    bit post_f [5] = '{1, 1, 1, 1, 0};
    logic [PB-1:0] eo;
    apply_reset();
    freespace_update = '1;
    empty = '0;
    for (int k = 0; k < 6; k++) begin
      eo = pre_f[k] ? fs_pkt(pre[k]) : op_word(pre[k], 0);
      tick();
      total++;
      if (stream_out !== eo)
        $display("FAIL mid_pre[%0d]: got %h want %h", k, stream_out, eo);
      else pass_cnt++;
    end
    reset = 1'b1;
    #1;
    total++;
    if (freespace_ack !== '0 || outport_sel !== '0)
      $display("FAIL mid_rst_grant: ack=%h sel=%h want 0 0", freespace_ack, outport_sel);
    else pass_cnt++;
    tick();
    total++;
    if (stream_out !== '0)
      $display("FAIL mid_rst_stream: got %h want 0", stream_out);
    else pass_cnt++;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      eo = post_f[k] ? fs_pkt(post[k]) : op_word(post[k], 0);
      tick();
      total++;
      if (stream_out !== eo)
        $display("FAIL mid_post[%0d]: got %h want %h", k, stream_out, eo);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset            = 1'b1;
    resend           = 1'b0;
    freespace_update = '0;
    empty            = '1;
    in_bus           = '0;
    out_bus          = '0;
    tick();
    test_reset();
    test_single_fifo();
    test_op_round_robin();
    test_fs_burst();
    test_resend();
    test_fs_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
